jk_updown_counter: RTL

Synchronous modulo-N up/down counter whose state register is built from per-bit JK cells, each driven by excitation logic derived from the desired next state. It is the stage directly feeding the JK flip-flops: it computes the J/K inputs each cycle from enable, direction and load controls. It provides a loadable, wrapping count with a terminal-count pulse for downstream sequencing.

---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_updown_counter_if.sv | 26 ++
 rtl/jk_cell.sv | 28 ++
 rtl/jk_updown_counter.sv | 109 ++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK-cell up/down counter: operating mode
// and the per-bit JK excitation derived from present and next state.
package jk_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      LOAD = 2'd1,
      INC  = 2'd2,
      DEC  = 2'd3
   } mode_e;

   // Set a rising bit and clear a falling bit; held bits get J=K=0, never a toggle.
   function automatic logic [1:0] jk_excite(input logic q, input logic n);
      return {~q & n, q & ~n};
   endfunction

endpackage

// File: rtl/jk_updown_counter_if.sv
// Control/status bundle of the JK up/down counter; the counter is the slave,
// the controlling block is the master.
interface jk_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_b;
   logic             tc;
   logic             load_err;
   logic [WIDTH-1:0] j_bus;
   logic [WIDTH-1:0] k_bus;

   modport master (
      output en, up, load, din,
      input  count, count_b, tc, load_err, j_bus, k_bus
   );

   modport slave (
      input  en, up, load, din,
      output count, count_b, tc, load_err, j_bus, k_bus
   );
endinterface

// File: rtl/jk_cell.sv
// One JK flip-flop bit with synchronous active-low clear:
// 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qb
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

   // Complement is combinational so it tracks q even while held in reset.
   assign qb = ~q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from JK cells; computes the next state
// from load/en/up, derives J/K excitation, and registers tc and load_err.
module jk_updown_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   jk_updown_counter_if.slave  bus
);

   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] TOP_V = WIDTH'(MODULUS - 1);

   mode_e            mode;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;
   logic [WIDTH:0]   inc_w;
   logic [WIDTH:0]   dec_w;
   logic             wrap;
   logic             bad_load;
   logic             tc_p1;
   logic             load_err_p1;
   logic             unused_carry;

   always_comb begin
      mode = HOLD;
      if (bus.load)
         mode = LOAD;
      else if (bus.en)
         mode = bus.up ? INC : DEC;
   end

   assign inc_w        = {1'b0, q} + (WIDTH+1)'(1);
   assign dec_w        = {1'b0, q} - (WIDTH+1)'(1);
   assign unused_carry = ^{inc_w[WIDTH], dec_w[WIDTH]};

   // Wrap is decided on the untruncated compare; the sum is truncated afterwards,
   // so MODULUS = 2^WIDTH still flags tc on the natural rollover.
   always_comb begin
      next_q   = q;
      wrap     = 1'b0;
      bad_load = 1'b0;
      case (mode)
         LOAD: begin
            if ({1'b0, bus.din} < MOD_W) begin
               next_q = bus.din;
            end else begin
               next_q   = '0;
               bad_load = 1'b1;
            end
         end
         INC: begin
            if (q == TOP_V) begin
               next_q = '0;
               wrap   = 1'b1;
            end else begin
               next_q = inc_w[WIDTH-1:0];
            end
         end
         DEC: begin
            if (q == '0) begin
               next_q = TOP_V;
               wrap   = 1'b1;
            end else begin
               next_q = dec_w[WIDTH-1:0];
            end
         end
         default: next_q = q;
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign {j_vec[i], k_vec[i]} = jk_excite(q[i], next_q[i]);

      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (j_vec[i]),
         .k     (k_vec[i]),
         .q     (q[i]),
         .qb    (qb[i])
      );
   end

   // Stage p1: status pulses aligned with the count they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tc_p1       <= 1'b0;
         load_err_p1 <= 1'b0;
      end else begin
         tc_p1       <= wrap;
         load_err_p1 <= bad_load;
      end
   end

   assign bus.count    = q;
   assign bus.count_b  = qb;
   assign bus.tc       = tc_p1;
   assign bus.load_err = load_err_p1;
   assign bus.j_bus    = j_vec;
   assign bus.k_bus    = k_vec;

endmodule
